// File: rtl/clock_reset_gen.sv
`default_nettype none
// ============================================================================
//  Module      : clock_reset_gen
//  Description : Reset conditioner for the JAM-1 main bus. Synchronises the
//                asynchronous active-low reset button into the clk domain,
//                stretches its release by HOLD_CYCLES and drives a registered,
//                glitch-free active-low system reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module clock_reset_gen #(
  parameter int SYNC_STAGES = 2,  // synchroniser depth, >= 2
  parameter int HOLD_CYCLES = 4   // extra low cycles after release, >= 1
) (
  input  logic clk,
  input  logic rst,
  input  logic reset_in_n,
  output logic reset_out_n
);

  // Hold counter width: must be able to represent HOLD_CYCLES itself.
  localparam int CW = $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0] C_HOLD = CW'(HOLD_CYCLES);
  localparam logic [CW-1:0] C_ONE  = CW'(1);
  localparam logic [CW-1:0] C_ZERO = '0;

  // State encoding: bit 0 is the released-reset level, so the output is the
  // plain Q of a state flop and can never glitch through decode logic.
  localparam logic [1:0] ST_ASSERT = 2'b00;
  localparam logic [1:0] ST_HOLD   = 2'b10;
  localparam logic [1:0] ST_RUN    = 2'b01;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_sync_out;
  logic [CW-1:0]          r_cnt;
  logic [CW-1:0]          w_cnt_nxt;
  logic [1:0]             r_state;
  logic [1:0]             w_state_nxt;

  // Synchroniser: pure shift chain, cleared by rst, no logic between stages.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], reset_in_n};
    end
  end

  assign w_sync_out = r_sync[SYNC_STAGES-1];

  // State register: state and hold counter; rst forces ASSERT with a full count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_ASSERT;
      r_cnt   <= C_HOLD;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state logic: a low synchronised button always re-arms the full hold;
  // otherwise count down to zero before entering RUN.
  always_comb begin
    w_state_nxt = ST_ASSERT;
    w_cnt_nxt   = C_HOLD;
    if (rst || !w_sync_out) begin
      w_state_nxt = ST_ASSERT;
      w_cnt_nxt   = C_HOLD;
    end else begin
      case (r_state)
        ST_ASSERT, ST_HOLD: begin
          if (r_cnt != C_ZERO) begin
            w_state_nxt = ST_HOLD;
            w_cnt_nxt   = r_cnt - C_ONE;
          end else begin
            w_state_nxt = ST_RUN;
            w_cnt_nxt   = C_ZERO;
          end
        end
        ST_RUN: begin
          w_state_nxt = ST_RUN;
          w_cnt_nxt   = C_ZERO;
        end
        default: begin
          // Unreachable encoding: recover by re-asserting reset.
          w_state_nxt = ST_ASSERT;
          w_cnt_nxt   = C_HOLD;
        end
      endcase
    end
  end

  // Output: the RUN bit of the state register, straight from a flop.
  always_comb begin
    reset_out_n = r_state[0];
  end

endmodule
`default_nettype wire

// File: tb/tb_clock_reset_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_clock_reset_gen
//  Description : Scoreboard bench for clock_reset_gen. Default-parameter and
//                SYNC_STAGES=3/HOLD_CYCLES=1 instances driven by directed
//                vectors with hand-computed expected reset_out_n.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_clock_reset_gen;

  typedef struct {
    logic exp;
    int   id;
  } exp_t;

  logic clk;
  logic rst_a, rin_a, rout_a;
  logic rst_b, rin_b, rout_b;

  exp_t q_a[$];
  exp_t q_b[$];

  int checks;
  int failures;
  int vec_id;

  clock_reset_gen u_dut_a (
    .clk         (clk),
    .rst         (rst_a),
    .reset_in_n  (rin_a),
    .reset_out_n (rout_a)
  );

  clock_reset_gen #(
    .SYNC_STAGES (3),
    .HOLD_CYCLES (1)
  ) u_dut_b (
    .clk         (clk),
    .rst         (rst_b),
    .reset_in_n  (rin_b),
    .reset_out_n (rout_b)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  // Drive one cycle of instance A and queue the reset_out_n expected after
  // the following rising edge.
  task automatic step_a(input logic r, input logic rin, input logic e);
    exp_t x;
    rst_a = r;
    rin_a = rin;
    x.exp = e;
    x.id  = vec_id;
    q_a.push_back(x);
    vec_id++;
    @(negedge clk);
  endtask

  task automatic run_a(input int n, input logic r, input logic rin, input logic e);
    for (int i = 0; i < n; i++) step_a(r, rin, e);
  endtask

  task automatic step_b(input logic r, input logic rin, input logic e);
    exp_t x;
    rst_b = r;
    rin_b = rin;
    x.exp = e;
    x.id  = vec_id;
    q_b.push_back(x);
    vec_id++;
    @(negedge clk);
  endtask

  task automatic run_b(input int n, input logic r, input logic rin, input logic e);
    for (int i = 0; i < n; i++) step_b(r, rin, e);
  endtask

  // Monitor: one expected value per edge for whichever instance has one queued.
  always @(posedge clk) begin
    exp_t xa;
    exp_t xb;
    #1;
    if (q_a.size() > 0) begin
      xa = q_a.pop_front();
      checks++;
      if (rout_a !== xa.exp) begin
        failures++;
        $display("FAIL dutA vec%0d t=%0t reset_out_n got=%b want=%b", xa.id, $time, rout_a, xa.exp);
      end
    end
    if (q_b.size() > 0) begin
      xb = q_b.pop_front();
      checks++;
      if (rout_b !== xb.exp) begin
        failures++;
        $display("FAIL dutB vec%0d t=%0t reset_out_n got=%b want=%b", xb.id, $time, rout_b, xb.exp);
      end
    end
  end

  initial begin
    checks   = 0;
    failures = 0;
    vec_id   = 0;
    rst_b    = 1'b1;
    rin_b    = 1'b1;

    // ---- Instance A, default parameters (edges at 10, 30, ...) ----
    // Power-up press: rst for two edges with the button held.
    run_a(2, 1'b1, 1'b0, 1'b0);            // edges 10, 30
    // Release sampled at 50: low through 150, high at 170.
    run_a(6, 1'b0, 1'b1, 1'b0);            // edges 50..150
    run_a(4, 1'b0, 1'b1, 1'b1);            // edges 170..230
    // Single-cycle press sampled at 250: low 290..370, high at 390.
    step_a(1'b0, 1'b0, 1'b1);              // edge 250
    step_a(1'b0, 1'b1, 1'b1);              // edge 270
    run_a(5, 1'b0, 1'b1, 1'b0);            // edges 290..370
    run_a(3, 1'b0, 1'b1, 1'b1);            // edges 390..430
    // Press at 450, then re-press at 530 while holding; release of the
    // second press sampled at 550 gives the rise at 670 with no high glitch.
    step_a(1'b0, 1'b0, 1'b1);              // edge 450
    step_a(1'b0, 1'b1, 1'b1);              // edge 470
    step_a(1'b0, 1'b1, 1'b0);              // edge 490
    step_a(1'b0, 1'b1, 1'b0);              // edge 510
    step_a(1'b0, 1'b0, 1'b0);              // edge 530
    run_a(5, 1'b0, 1'b1, 1'b0);            // edges 550..630
    step_a(1'b0, 1'b1, 1'b0);              // edge 650
    run_a(3, 1'b0, 1'b1, 1'b1);            // edges 670..710
    // rst for one edge during RUN; first rst=0 edge 750, high again at 870.
    step_a(1'b1, 1'b1, 1'b0);              // edge 730
    run_a(6, 1'b0, 1'b1, 1'b0);            // edges 750..850
    run_a(2, 1'b0, 1'b1, 1'b1);            // edges 870, 890

    // ---- Instance B, SYNC_STAGES=3, HOLD_CYCLES=1 ----
    run_b(2, 1'b1, 1'b1, 1'b0);            // rst
    run_b(4, 1'b0, 1'b1, 1'b0);            // release latency 4 edges
    run_b(3, 1'b0, 1'b1, 1'b1);
    step_b(1'b0, 1'b0, 1'b1);              // press sampled at edge P
    step_b(1'b0, 1'b1, 1'b1);              // P+1
    step_b(1'b0, 1'b1, 1'b1);              // P+2
    run_b(2, 1'b0, 1'b1, 1'b0);            // P+3, P+4: asserted
    run_b(2, 1'b0, 1'b1, 1'b1);            // P+5: released

    // Let the monitor consume everything still queued.
    repeat (3) @(negedge clk);
    checks++;
    if ((q_a.size() + q_b.size()) != 0) begin
      failures++;
      $display("FAIL drain queued got=%0d want=0", q_a.size() + q_b.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
